// File: rtl/hex_dec_display.sv
// hex_dec_display: loads a 32-bit binary value, converts it to decimal with a
// bit-serial shift-and-add-3 engine (one bit per clock) and drives eight
// registered, active-low seven-segment patterns (hex0 = least significant digit).
// Optional leading-zero blanking is enabled by defining HEX_LZB_EN.
module hex_dec_display (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5,
  output logic [7:0]  hex6,
  output logic [7:0]  hex7
);

  localparam logic [7:0] SegZero  = 8'hC0;
  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegDash  = 8'hBF;
`ifdef HEX_LZB_EN
  localparam logic [7:0] RstUpper = SegBlank;
`else
  localparam logic [7:0] RstUpper = SegZero;
`endif

  typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

  state_e           state_q;
  logic [31:0]      shift_q;
  logic [39:0]      bcd_q;
  logic [5:0]       cnt_q;
  logic [7:0][7:0]  hex_q;
  logic             busy_q;
  logic             done_q;
  logic [39:0]      bcd_adj;
  logic [7:0][7:0]  seg_d;

  // Decimal digit to active-low gfedcba pattern, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 10; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
    end
  end

  // Segment patterns for the finished conversion: digits, optional blanking, overflow dash.
  always_comb begin
    logic seen;
    logic ovf;
    seg_d = '0;
    seen  = 1'b0;
    ovf   = |bcd_q[39:32];
    for (int i = 7; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
      seg_d[i] = seg7(bcd_q[4*i +: 4]);
`ifdef HEX_LZB_EN
      if (!seen && i != 0) seg_d[i] = SegBlank;
`endif
      if (ovf) seg_d[i] = SegDash;
    end
  end

  // Control FSM with conversion datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= {{7{RstUpper}}, SegZero};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shift_q <= value;
            bcd_q   <= '0;
            cnt_q   <= 6'd32;
            busy_q  <= 1'b1;
            state_q <= StConv;
          end
        end
        StConv: begin
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          cnt_q            <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_q <= StUpdate;
        end
        StUpdate: begin
          hex_q   <= seg_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule

// File: tb/tb_hex_dec_display.sv
// Scoreboard bench for hex_dec_display: stimulus pushes expected {hex7..hex0},
// a monitor pops and compares on every done pulse.
module tb_hex_dec_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] value;
  logic        load;
  logic        busy, done;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [63:0] hex_all;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  logic [63:0] sb[$];

`ifdef HEX_LZB_EN
  localparam logic [63:0] ExpRst  = 64'hFFFFFFFF_FFFFFFC0;
  localparam logic [63:0] ExpZero = 64'hFFFFFFFF_FFFFFFC0;
  localparam logic [63:0] Exp1050 = 64'hFFFFFFFF_F9C092C0;
  localparam logic [63:0] Exp5    = 64'hFFFFFFFF_FFFFFF92;
  localparam logic [63:0] Exp6    = 64'hFFFFFFFF_FFFFFF82;
  localparam logic [63:0] Exp90   = 64'hFFFFFFFF_FFFF90C0;
`else
  localparam logic [63:0] ExpRst  = 64'hC0C0C0C0_C0C0C0C0;
  localparam logic [63:0] ExpZero = 64'hC0C0C0C0_C0C0C0C0;
  localparam logic [63:0] Exp1050 = 64'hC0C0C0C0_F9C092C0;
  localparam logic [63:0] Exp5    = 64'hC0C0C0C0_C0C0C092;
  localparam logic [63:0] Exp6    = 64'hC0C0C0C0_C0C0C082;
  localparam logic [63:0] Exp90   = 64'hC0C0C0C0_C0C090C0;
`endif
  localparam logic [63:0] Exp12345678 = 64'hF9A4B099_9282F880;
  localparam logic [63:0] ExpNines    = 64'h90909090_90909090;
  localparam logic [63:0] ExpDash     = 64'hBFBFBFBF_BFBFBFBF;

  hex_dec_display dut (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .load    (load),
    .busy    (busy),
    .done    (done),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5),
    .hex6    (hex6),
    .hex7    (hex7)
  );

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        chk("display", hex_all, sb.pop_front());
      end
    end
  end

  // Wait for done after an accepted load; checks latency, busy and pulse width.
  task automatic wait_done(input int exp_lat, input string name);
    int lat = 0;
    bit busy_ok = 1'b1;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy_during"}, 64'(busy_ok), 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({name, "_done_width"}, 64'(done), 64'd0);
  endtask

  // Issue one load (accepted at the next edge) and return with load low.
  task automatic issue(input logic [31:0] v, input logic [63:0] exp, input string name);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    load  = 1'b0;
    value = $urandom;
    chk({name, "_busy_after_accept"}, 64'(busy), 64'd1);
  endtask

  task automatic run_load(input logic [31:0] v, input logic [63:0] exp, input string name);
    issue(v, exp, name);
    wait_done(33, name);
  endtask

  initial begin
    int dc;
    reset_n = 1'b0;
    load    = 1'b0;
    value   = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hex", hex_all, ExpRst);
    @(negedge clk);
    reset_n = 1'b1;

    run_load(32'd12345678, Exp12345678, "v12345678");
    run_load(32'd0, ExpZero, "v0");
    run_load(32'd1050, Exp1050, "v1050");
    run_load(32'd99999999, ExpNines, "v99999999");
    run_load(32'd100000000, ExpDash, "v100000000");
    run_load(32'hFFFFFFFF, ExpDash, "vffffffff");

    // Load during conversion is ignored.
    dc = done_count;
    issue(32'd12345678, Exp12345678, "ignore");
    repeat (4) @(posedge clk);
    #1;
    load  = 1'b1;
    value = 32'd7;
    @(posedge clk); #1;
    load = 1'b0;
    wait_done(28, "ignore");
    repeat (40) @(posedge clk);
    #1;
    chk("ignore_done_count", 64'(done_count - dc), 64'd1);

    // Reset mid-conversion aborts with no done pulse.
    issue(32'd87654321, 64'h0, "abort");
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hex", hex_all, ExpRst);
    dc = done_count;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_count - dc), 64'd0);
    run_load(32'd90, Exp90, "after_abort");

    // Back-to-back with load held high: 5 then 6, done 34 cycles apart.
    @(negedge clk);
    value = 32'd5;
    load  = 1'b1;
    sb.push_back(Exp5);
    sb.push_back(Exp6);
    @(posedge clk); #1;
    value = 32'd6;
    wait_done(33, "b2b_first");
    load = 1'b0;
    chk("b2b_second_accept", 64'(busy), 64'd1);
    wait_done(33, "b2b_second");

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
